// File: rtl/rv_imem_resp_if.sv
// Fetch/loader bus between the fetch stage (master) and the instruction-memory
// responder (slave).
interface rv_imem_resp_if #(
  parameter int IADDR_SPACE_BITS = 16
);
  logic                        i_cyc;
  logic [IADDR_SPACE_BITS-1:0] i_addr;
  logic                        o_ack;
  logic [31:0]                 o_instruction;
  logic                        i_wr_en;
  logic [IADDR_SPACE_BITS-1:0] i_wr_addr;
  logic [31:0]                 i_wr_data;
  logic [3:0]                  i_wr_be;
  logic                        o_busy;

  modport master (
    output i_cyc, i_addr, i_wr_en, i_wr_addr, i_wr_data, i_wr_be,
    input  o_ack, o_instruction, o_busy
  );

  modport slave (
    input  i_cyc, i_addr, i_wr_en, i_wr_addr, i_wr_data, i_wr_be,
    output o_ack, o_instruction, o_busy
  );
endinterface

// File: rtl/rv_imem_resp.sv
// Instruction-bus responder: acks fetch requests after WAIT_STATES cycles and
// returns the word one cycle later; a byte-enabled loader port fills the array.
module rv_imem_resp #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int MEM_WORDS_BITS   = 12,
  parameter int WAIT_STATES      = 0
) (
  input logic           i_clk,
  input logic           i_reset,
  rv_imem_resp_if.slave bus
);
  localparam int WCNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
  localparam int WA_W   = IADDR_SPACE_BITS - 2;
  localparam int DEPTH  = 1 << MEM_WORDS_BITS;
  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(WAIT_STATES);

  logic [31:0] mem [0:DEPTH-1];

  logic [WA_W-1:0]           wa_q;
  logic                      wa_vld_q;
  logic [WCNT_W-1:0]         wcnt_q, wcnt_d, wcnt_cur;
  logic [31:0]               instr_q;
  logic                      ack, new_req;
  logic [MEM_WORDS_BITS-1:0] rd_idx, wr_idx;
  logic                      addr_unused;

  assign rd_idx      = bus.i_addr[MEM_WORDS_BITS+1:2];
  assign wr_idx      = bus.i_wr_addr[MEM_WORDS_BITS+1:2];
  assign addr_unused = ^{bus.i_wr_addr, bus.i_addr[1:0]};

  // A new word address counts as count 0 in its first cycle, so a stable
  // request is acked exactly WAIT_STATES cycles after it first appears.
  always_comb begin
    new_req  = !wa_vld_q || (bus.i_addr[IADDR_SPACE_BITS-1:2] != wa_q);
    wcnt_cur = new_req ? '0 : wcnt_q;
    ack      = bus.i_cyc & !bus.i_wr_en & (wcnt_cur == WMAX) & !i_reset;
    wcnt_d   = wcnt_cur;
    if (!bus.i_cyc || ack)   wcnt_d = '0;
    else if (wcnt_cur != WMAX) wcnt_d = wcnt_cur + 1'b1;
  end

  assign bus.o_ack         = ack;
  assign bus.o_busy        = bus.i_cyc & !ack & !i_reset;
  assign bus.o_instruction = instr_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wa_q     <= '1;
      wa_vld_q <= 1'b0;
      wcnt_q   <= '0;
      instr_q  <= '0;
    end else begin
      wa_q     <= bus.i_addr[IADDR_SPACE_BITS-1:2];
      wa_vld_q <= 1'b1;
      wcnt_q   <= wcnt_d;
      if (ack) instr_q <= mem[rd_idx];
    end
  end

  // Array contents are never reset; writes and acked reads never share a cycle.
  always_ff @(posedge i_clk) begin
    if (bus.i_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.i_wr_be[b]) mem[wr_idx][8*b +: 8] <= bus.i_wr_data[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_rv_imem_resp.sv
// Directed bench for rv_imem_resp: three instances cover W=0, W=3 and a
// 16-word W=2 array for aliasing and async-reset behaviour.
module tb_rv_imem_resp;
  logic clk = 1'b0;
  logic r0, r3, r2;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  rv_imem_resp_if #(.IADDR_SPACE_BITS(16)) b0();
  rv_imem_resp_if #(.IADDR_SPACE_BITS(16)) b3();
  rv_imem_resp_if #(.IADDR_SPACE_BITS(16)) b2();

  rv_imem_resp #(.IADDR_SPACE_BITS(16), .MEM_WORDS_BITS(12), .WAIT_STATES(0))
    dut0 (.i_clk(clk), .i_reset(r0), .bus(b0));
  rv_imem_resp #(.IADDR_SPACE_BITS(16), .MEM_WORDS_BITS(12), .WAIT_STATES(3))
    dut3 (.i_clk(clk), .i_reset(r3), .bus(b3));
  rv_imem_resp #(.IADDR_SPACE_BITS(16), .MEM_WORDS_BITS(4), .WAIT_STATES(2))
    dut2 (.i_clk(clk), .i_reset(r2), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_all(input logic [15:0] a, input logic [31:0] d);
    step();
    b0.i_wr_en = 1'b1; b0.i_wr_addr = a; b0.i_wr_data = d; b0.i_wr_be = 4'hF;
    b3.i_wr_en = 1'b1; b3.i_wr_addr = a; b3.i_wr_data = d; b3.i_wr_be = 4'hF;
    b2.i_wr_en = 1'b1; b2.i_wr_addr = a; b2.i_wr_data = d; b2.i_wr_be = 4'hF;
  endtask

  task automatic wr_end();
    step();
    b0.i_wr_en = 1'b0; b3.i_wr_en = 1'b0; b2.i_wr_en = 1'b0;
  endtask

  logic [31:0] prog [0:4];

  initial begin
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093; prog[2] = 32'h0020_0113;
    prog[3] = 32'h0030_0193; prog[4] = 32'hCAFE_0004;

    r0 = 1'b1; r3 = 1'b1; r2 = 1'b1;
    b0.i_cyc = 1'b1; b0.i_addr = '0; b0.i_wr_en = 1'b0; b0.i_wr_addr = '0; b0.i_wr_data = '0; b0.i_wr_be = '0;
    b3.i_cyc = 1'b0; b3.i_addr = '0; b3.i_wr_en = 1'b0; b3.i_wr_addr = '0; b3.i_wr_data = '0; b3.i_wr_be = '0;
    b2.i_cyc = 1'b0; b2.i_addr = '0; b2.i_wr_en = 1'b0; b2.i_wr_addr = '0; b2.i_wr_data = '0; b2.i_wr_be = '0;
    #2;
    chk("rst_ack",   {31'b0, b0.o_ack},  32'd0);
    chk("rst_busy",  {31'b0, b0.o_busy}, 32'd0);
    chk("rst_instr", b0.o_instruction,   32'd0);

    step();
    r0 = 1'b0; r3 = 1'b0; r2 = 1'b0;
    b0.i_cyc = 1'b0;
    for (int i = 0; i < 5; i++) wr_all(16'(i * 4), prog[i]);
    wr_end();

    // W=0 streaming: one word per cycle
    b0.i_cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      b0.i_addr = 16'(i * 4);
      #2;
      chk($sformatf("w0_ack%0d", i), {31'b0, b0.o_ack}, 32'd1);
      if (i != 0) chk($sformatf("w0_data%0d", i - 1), b0.o_instruction, prog[i-1]);
    end
    step(); b0.i_cyc = 1'b0; #2;
    chk("w0_data3", b0.o_instruction, prog[3]);
    chk("w0_idle_ack", {31'b0, b0.o_ack}, 32'd0);

    // W=3 stable address
    step(); b3.i_cyc = 1'b1; b3.i_addr = 16'h0008;
    for (int t = 0; t < 4; t++) begin
      if (t != 0) step();
      #2;
      chk($sformatf("w3_ack_T%0d", t),  {31'b0, b3.o_ack},  (t == 3) ? 32'd1 : 32'd0);
      chk($sformatf("w3_busy_T%0d", t), {31'b0, b3.o_busy}, (t == 3) ? 32'd0 : 32'd1);
    end
    step(); b3.i_cyc = 1'b0; #2;
    chk("w3_data", b3.o_instruction, prog[2]);

    // W=3 address change mid-wait
    step(); b3.i_cyc = 1'b1; b3.i_addr = 16'h0004;
    for (int t = 0; t < 6; t++) begin
      if (t != 0) step();
      if (t == 2) b3.i_addr = 16'h0010;
      #2;
      chk($sformatf("chg_ack_T%0d", t), {31'b0, b3.o_ack}, (t == 5) ? 32'd1 : 32'd0);
    end
    chk("chg_hold", b3.o_instruction, prog[2]);
    step(); b3.i_cyc = 1'b0; #2;
    chk("chg_data", b3.o_instruction, prog[4]);

    // Aliasing: 16-word array, address 0x42 -> word 0
    step(); b2.i_cyc = 1'b1; b2.i_addr = 16'h0042;
    for (int t = 0; t < 3; t++) begin
      if (t != 0) step();
      #2;
      chk($sformatf("alias_ack_T%0d", t), {31'b0, b2.o_ack}, (t == 2) ? 32'd1 : 32'd0);
    end
    step(); b2.i_cyc = 1'b0; #2;
    chk("alias_data", b2.o_instruction, prog[0]);

    // Async reset mid-wait, W=2
    step(); b2.i_cyc = 1'b1; b2.i_addr = 16'h0008;
    step(); #2;
    chk("ar_pre_busy", {31'b0, b2.o_busy}, 32'd1);
    #1; r2 = 1'b1; #1;
    chk("ar_ack",   {31'b0, b2.o_ack},  32'd0);
    chk("ar_busy",  {31'b0, b2.o_busy}, 32'd0);
    chk("ar_instr", b2.o_instruction,   32'd0);
    step(); r2 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (t != 0) step();
      #2;
      chk($sformatf("ar_post_ack_T%0d", t), {31'b0, b2.o_ack}, (t == 2) ? 32'd1 : 32'd0);
    end
    step(); b2.i_cyc = 1'b0; #2;
    chk("ar_post_data", b2.o_instruction, prog[2]);

    // Write conflict, W=0: byte-enabled write wins over the fetch
    wr_all(16'h0000, 32'h1234_5678);
    wr_end();
    b0.i_cyc = 1'b1; b0.i_addr = 16'h0000;
    b0.i_wr_en = 1'b1; b0.i_wr_addr = 16'h0000; b0.i_wr_data = 32'hAAAA_5555; b0.i_wr_be = 4'b0011;
    #2;
    chk("wc_ack_wr",  {31'b0, b0.o_ack},  32'd0);
    chk("wc_busy_wr", {31'b0, b0.o_busy}, 32'd1);
    step(); b0.i_wr_en = 1'b0; #2;
    chk("wc_ack_next", {31'b0, b0.o_ack}, 32'd1);
    step(); b0.i_cyc = 1'b0; #2;
    chk("wc_data", b0.o_instruction, 32'h1234_5555);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/rv_imem_resp.md
# rv_imem_resp

Instruction-bus responder that answers the fetch unit's word requests from an internal single-port synchronous instruction memory. It sits on the instruction side of the core, opposite the fetch stage. It accepts an address with `i_cyc` and signals acceptance with `o_ack`, then returns the addressed 32-bit word on the following cycle. A programmable wait-state counter models slower memories, and a byte-enabled loader write port fills the array before or during execution.

## Interface
Parameters:
- `IADDR_SPACE_BITS`, 16: width of the fetch byte address.
- `MEM_WORDS_BITS`, 12: log2 of the memory depth in 32-bit words; must be ≤ `IADDR_SPACE_BITS`-2.
- `WAIT_STATES`, 0: cycles inserted before each ack; legal range 0..15.

Ports:
- `i_clk`, in, 1: the single clock; all state changes on its rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_cyc`, in, 1: fetch request valid.
- `i_addr`, in, `IADDR_SPACE_BITS`: fetch byte address. Bits [1:0] are ignored, so the word is always aligned.
- `o_ack`, out, 1: request accepted this cycle; data follows next cycle.
- `o_instruction`, out, 32: word for the last acked address.
- `i_wr_en`, in, 1: loader write strobe.
- `i_wr_addr`, in, `IADDR_SPACE_BITS`: loader byte address; bits [1:0] are ignored.
- `i_wr_data`, in, 32: loader write data.
- `i_wr_be`, in, 4: byte enables; bit n covers data[8n+7:8n].
- `o_busy`, out, 1: a request is pending and not yet acked.

## Operation
- Word index = `i_addr[MEM_WORDS_BITS+1:2]`. Upper address bits are ignored, so the memory aliases modulo its size. The same rule applies to `i_wr_addr`.
- The wait counter `wcnt` has width ceil(log2(`WAIT_STATES`+1)), minimum 1 bit.
  - It clears when `i_cyc`=0, when `i_addr[IADDR_SPACE_BITS-1:2]` differs from the previous cycle's value, or in any cycle with `o_ack`=1.
  - Otherwise it increments, saturating at `WAIT_STATES`.
- The responder keeps a registered copy of the previous cycle's word address for the change comparison.
  - The register updates every cycle.
  - Its reset value is all-ones with a valid bit of 0, so the first request after reset is always treated as new.
- `o_ack` = `i_cyc` & !`i_wr_en` & (`wcnt` == `WAIT_STATES`) & !`i_reset`. The ack is combinational from these terms.
- Read: in a cycle with `o_ack`=1, the memory reads the indexed word, and `o_instruction` takes it at the next edge. In all other cycles `o_instruction` holds its value.
- Write: in a cycle with `i_wr_en`=1, each byte with its enable set is written at the edge. The write has priority over a fetch and suppresses `o_ack` in that cycle. `wcnt` does not clear, so the pending request is acked in the first cycle without a write.
- Read-during-write to the same word cannot happen, because ack is suppressed in write cycles.
- `o_busy` = `i_cyc` & !`o_ack`.
- Memory contents are not reset.

## Timing
- Reset values: `o_ack`=0, `o_instruction`=0, `o_busy`=0, `wcnt`=0.
- A reset asserted mid-request drops the request. After release, the request restarts with a full wait.
- `WAIT_STATES`=0:
  - Ack is in the same cycle as the address, with data at cycle +1.
  - Consecutive addresses are acked every cycle, giving 1 word per cycle.
- `WAIT_STATES`=W:
  - An address first presented in cycle T and held stable is acked in cycle T+W, with data valid in cycle T+W+1.
  - After an ack, the next request, including one with the same address, waits W cycles again.
- If the address changes before ack, the wait restarts from the new address; the old request is abandoned and produces no data.
- If `i_cyc` drops before ack, the request is abandoned.
- `o_instruction` is stable from the cycle after an ack until the cycle after the next ack. A flush in the requester needs no cooperation from the responder.

## Test plan
- Reset and W=0:
  - Stimulus: load mem[0..3] = 0x00000013, 0x00100093, 0x00200113, 0x00300193; release reset; hold `i_cyc`=1 and step `i_addr` 0,4,8,C one per cycle.
  - Required: `o_ack`=1 in each of those cycles, and `o_instruction` = those four words in the following four cycles.
- W=3:
  - Stimulus: hold `i_addr`=0x8 from cycle T.
  - Required: `o_ack`=0 for T..T+2 with `o_busy`=1; `o_ack`=1 at T+3; `o_instruction`=mem[2] at T+4.
- Address change mid-wait, W=3:
  - Stimulus: address 0x4 at T, changed to 0x10 at T+2.
  - Required: no ack for 0x4; ack at T+5; data = mem[4].
- Write conflict, W=0:
  - Stimulus: `i_cyc`=1 at address 0x0 with `i_wr_en`=1, `i_wr_be`=4'b0011, data 0xAAAA5555 to 0x0 (old value 0x12345678).
  - Required: `o_ack`=0 in the write cycle, `o_ack`=1 next cycle, then `o_instruction`=0x12345555.
- Aliasing and alignment:
  - Stimulus: `MEM_WORDS_BITS`=4; fetch address 0x42.
  - Required: returns mem[0].
- Async reset mid-wait:
  - Stimulus: W=2; assert `i_reset` between edges while a request is pending.
  - Required: `o_ack`, `o_busy` and `o_instruction` go to 0 immediately; after release, a request held stable is acked 2 cycles after its first post-reset cycle.
